// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared state encoding and sizing helper for the batch accumulator
package acc_pkg;

    localparam logic ST_ACC  = 1'b0;
    localparam logic ST_DONE = 1'b1;

    // A one-operand batch still needs a legal (1-bit) counter.
    function automatic int cnt_width(input int len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

endpackage

// File: rtl/adder_rc.sv
// rtl/adder_rc.sv - N-bit ripple-carry adder with carry-in and carry-out
module adder_rc #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] sum,
    output logic         co
);

    logic carry;

    // Carry ripples bit by bit through a single variable, LSB first.
    always_comb begin
        carry = ci;
        sum   = '0;
        for (int i = 0; i < N; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
    end

    assign co = carry;

endmodule

// File: rtl/acc_rc.sv
// rtl/acc_rc.sv - batch accumulator: sums LEN operands, presents total and sticky overflow
module acc_rc
    import acc_pkg::*;
#(
    parameter int N   = 8,
    parameter int LEN = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         overflow
);

    localparam int            CW       = cnt_width(LEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(LEN - 1);

    logic          state;
    logic [N-1:0]  acc;
    logic          ovf;
    logic [CW-1:0] cnt;
    logic [N-1:0]  add_sum;
    logic          add_co;

    adder_rc #(.N(N)) u_add (
        .a   (acc),
        .b   (in_data),
        .ci  (1'b0),
        .sum (add_sum),
        .co  (add_co)
    );

    assign in_ready  = (state == ST_ACC);
    assign out_valid = (state == ST_DONE);
    assign sum       = acc;
    assign overflow  = ovf;

    // clear outranks both handshakes, so an operand offered alongside it is dropped.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_ACC;
            acc   <= '0;
            ovf   <= 1'b0;
            cnt   <= '0;
        end else if (clear) begin
            state <= ST_ACC;
            acc   <= '0;
            ovf   <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_ACC: begin
                    if (in_valid) begin
                        acc <= add_sum;
                        ovf <= ovf | add_co;
                        if (cnt == CNT_LAST) begin
                            cnt   <= '0;
                            state <= ST_DONE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    if (out_ready) begin
                        acc   <= '0;
                        ovf   <= 1'b0;
                        state <= ST_ACC;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acc_rc.sv
// tb/tb_acc_rc.sv - directed self-checking bench for acc_rc (LEN=4 and LEN=1)
module tb_acc_rc;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       clear;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       overflow;

    logic       in_valid1;
    logic       in_ready1;
    logic [7:0] in_data1;
    logic       out_valid1;
    logic       out_ready1;
    logic [7:0] sum1;
    logic       overflow1;

    int passed = 0;
    int total  = 0;

    always #5 clock = ~clock;

    acc_rc #(.N(8), .LEN(4)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .overflow  (overflow)
    );

    acc_rc #(.N(8), .LEN(1)) dut1 (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (1'b0),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_data   (in_data1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum       (sum1),
        .overflow  (overflow1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic feed(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [7:0] s, input logic o);
        check({tag, "_out_valid"}, out_valid, 1);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_sum"}, sum, s);
        check({tag, "_overflow"}, overflow, o);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        clear      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        in_valid1  = 1'b0;
        in_data1   = '0;
        out_ready1 = 1'b0;
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_overflow", overflow, 0);
        check("rst1_in_ready", in_ready1, 1);
        check("rst1_out_valid", out_valid1, 0);
        reset_n = 1'b1;
        tick();

        // 1: back-to-back 1,2,3,4
        in_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            in_data = 8'(k);
            tick();
            if (k < 4) check("s1_in_ready_mid", in_ready, 1);
        end
        in_valid = 1'b0;
        check_result("s1", 8'd10, 1'b0);
        handoff();
        check("s1_ho_out_valid", out_valid, 0);
        check("s1_ho_in_ready", in_ready, 1);
        check("s1_ho_sum", sum, 0);

        // 2: wrap-around with overflow
        feed(8'd200);
        feed(8'd100);
        feed(8'd0);
        feed(8'd0);
        check_result("s2", 8'd44, 1'b1);

        // 3: stall in DONE with a competing operand
        in_valid  = 1'b1;
        in_data   = 8'd77;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_result("s3_hold", 8'd44, 1'b1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("s3_out_valid_fall", out_valid, 0);
        check("s3_in_ready_rise", in_ready, 1);
        check("s3_sum_cleared", sum, 0);
        check("s3_ovf_cleared", overflow, 0);
        for (int k = 0; k < 4; k++) feed(8'd1);
        check_result("s2b", 8'd4, 1'b0);
        handoff();

        // 4: gapped stream, only valid beats count
        in_valid = 1'b1; in_data = 8'd5;  tick();
        in_valid = 1'b0; in_data = 8'd50; tick();
        in_valid = 1'b0; in_data = 8'd60; tick();
        in_valid = 1'b1; in_data = 8'd6;  tick();
        in_valid = 1'b1; in_data = 8'd7;  tick();
        in_valid = 1'b0; in_data = 8'd70; tick();
        check("s4_still_acc", in_ready, 1);
        check("s4_partial_sum", sum, 18);
        in_valid = 1'b1; in_data = 8'd8;  tick();
        in_valid = 1'b0;
        check_result("s4", 8'd26, 1'b0);
        handoff();

        // 5: clear drops a concurrent operand and the partial batch
        feed(8'd3);
        feed(8'd4);
        check("s5_partial", sum, 7);
        in_valid = 1'b1;
        in_data  = 8'd9;
        clear    = 1'b1;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        check("s5_clear_sum", sum, 0);
        check("s5_clear_in_ready", in_ready, 1);
        for (int k = 0; k < 4; k++) feed(8'd1);
        check_result("s5", 8'd4, 1'b0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("s5_clear_done_out_valid", out_valid, 0);
        check("s5_clear_done_sum", sum, 0);

        // 6: asynchronous reset mid-batch and in DONE
        feed(8'd5);
        feed(8'd6);
        check("s6_partial", sum, 11);
        #2;
        reset_n = 1'b0;
        #1;
        check("s6_mid_sum", sum, 0);
        check("s6_mid_in_ready", in_ready, 1);
        check("s6_mid_out_valid", out_valid, 0);
        reset_n = 1'b1;
        tick();
        feed(8'd255);
        feed(8'd2);
        feed(8'd0);
        check("s6_cnt_restart", in_ready, 1);
        feed(8'd0);
        check_result("s6", 8'd1, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("s6_done_out_valid", out_valid, 0);
        check("s6_done_in_ready", in_ready, 1);
        check("s6_done_sum", sum, 0);
        check("s6_done_overflow", overflow, 0);
        reset_n = 1'b1;
        tick();

        // LEN=1: every operand is a complete batch
        for (int k = 1; k <= 4; k++) begin
            in_valid1  = 1'b1;
            in_data1   = 8'(k);
            out_ready1 = 1'b0;
            tick();
            check("len1_out_valid", out_valid1, 1);
            check("len1_in_ready", in_ready1, 0);
            check("len1_sum", sum1, k);
            check("len1_overflow", overflow1, 0);
            out_ready1 = 1'b1;
            tick();
            check("len1_ho_out_valid", out_valid1, 0);
            check("len1_ho_sum", sum1, 0);
        end
        in_valid1  = 1'b0;
        out_ready1 = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
